// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares one synchronous sprite/background ROM read port between NREQ
// pixel-pipeline requesters. One request is granted per vga_clk edge. The
// winning address is registered onto the ROM port, and a tag pipeline of
// depth ROM_LAT steers the returning ROM word back to its requester as a
// one-cycle response strobe.
//
// Build option: define ROM_ARB_PRIORITY0_EN to give requester 0 (the
// background layer) absolute priority. Requester-0 wins leave the
// round-robin pointer untouched. Left undefined, the arbiter is a pure
// round robin over all requesters.
module rom_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 17,
  parameter int DW      = 4,
  parameter int ROM_LAT = 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_q,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data
);

  localparam int          IW     = $clog2(NREQ);
  localparam int          TW     = IW + 1;
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  // Requester index to one-hot strobe vector.
  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Modulo-NREQ addition of two in-range indices.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a,
                                             input logic [IW-1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NREQ_W) s = s - NREQ_W;
    return s[IW-1:0];
  endfunction

  logic [IW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   req_rr;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              rr_hit;
  logic [IW-1:0]     rr_off;
  logic              win_vld;
  logic [IW-1:0]     win_idx;

  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [AW-1:0]     rom_addr_q, rom_addr_d;
  logic [TW-1:0]     tag_q [ROM_LAT];
  logic [TW-1:0]     tag_head;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;

  // Select which requests take part in the rotating search.
  always_comb begin
`ifdef ROM_ARB_PRIORITY0_EN
    req_rr = {req[NREQ-1:1], 1'b0};
`else
    req_rr = req;
`endif
  end

  // Rotate the requests so that ptr sits at bit 0, then find the first set bit.
  always_comb begin
    req_dbl = {req_rr, req_rr};
    req_rot = NREQ'(req_dbl >> ptr_q);
    rr_hit  = 1'b0;
    rr_off  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rr_hit = 1'b1;
        rr_off = IW'(k);
      end
    end
  end

  // Resolve the winner and the next pointer value.
  always_comb begin
    win_vld = rr_hit;
    win_idx = wrap_add(ptr_q, rr_off);
    ptr_d   = rr_hit ? wrap_add(win_idx, IW'(1)) : ptr_q;
`ifdef ROM_ARB_PRIORITY0_EN
    if (req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
      ptr_d   = ptr_q;
    end
`endif
  end

  // Next grant strobe and ROM address; the address holds when nothing wins.
  always_comb begin
    gnt_d      = win_vld ? onehot(win_idx) : '0;
    rom_addr_d = win_vld ? addr[int'(win_idx)*AW +: AW] : rom_addr_q;
  end

  // Stage p0: arbitration result registered onto the ROM port.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      gnt_q      <= '0;
      rom_addr_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // Stages p0..p(ROM_LAT-1): tag pipeline that tracks each read in flight.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= {win_vld, win_idx};
      for (int k = 1; k < ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_head = tag_q[ROM_LAT-1];

  // Route the returning ROM word to the requester named by the head tag.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_head[TW-1]) begin
      rsp_valid_d = onehot(tag_head[IW-1:0]);
      rsp_data_d  = rom_q;
    end
  end

  // Stage p(ROM_LAT): response strobe and captured ROM data.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter. It uses a negedge-clocked ROM model that
// returns addr[3:0], and a queue-based reference model of the arbiter.
module tb_rom_port_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 17;
  localparam int DW      = 4;
  localparam int ROM_LAT = 3;

  logic               vga_clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [NREQ-1:0]    req     = '0;
  logic [NREQ*AW-1:0] addr    = '0;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_q;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;

  rom_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT)) dut (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM clocked on the inverted clock, returns the low address nibble after ROM_LAT cycles
  logic [DW-1:0] rom_pipe [ROM_LAT];
  always @(negedge vga_clk) begin
    rom_pipe[0] <= rom_addr[DW-1:0];
    for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  // Reference model state
  typedef struct { int due; int idx; logic [DW-1:0] data; } rsp_t;
  rsp_t            pend[$];
  int              m_ptr;
  int              cyc;
  logic [NREQ-1:0] e_gnt, e_rv;
  logic [AW-1:0]   e_addr;
  logic [DW-1:0]   e_data;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic m_reset();
    pend.delete();
    m_ptr  = 0;
    e_gnt  = '0;
    e_rv   = '0;
    e_addr = '0;
    e_data = '0;
  endtask

  // Advance one clock edge and compute what the outputs must be after it
  task automatic tick();
    int   w;
    bit   prio;
    rsp_t r;
    @(posedge vga_clk);
    cyc++;
    e_rv = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      e_rv[r.idx] = 1'b1;
      e_data = r.data;
    end
    w    = -1;
    prio = 1'b0;
`ifdef ROM_ARB_PRIORITY0_EN
    if (req[0]) begin
      w    = 0;
      prio = 1'b1;
    end
`endif
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    if (w >= 0) begin
      e_gnt    = '0;
      e_gnt[w] = 1'b1;
      e_addr   = addr[w*AW +: AW];
      pend.push_back('{cyc + ROM_LAT, w, addr[w*AW +: DW]});
      if (!prio) m_ptr = (w + 1) % NREQ;
    end else begin
      e_gnt = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    req     = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    #3;
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({gnt, rom_addr, rsp_valid, rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial gnt=%b rom_addr=%h rsp_valid=%b rsp_data=%h want all 0",
               gnt, rom_addr, rsp_valid, rsp_data);
    end
    do_reset();
    for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = AW'(32'h100 * (i + 1) + i + 3);
    req = 4'b1111;
    repeat (2) begin
      tick();
      n_chk++;
      if ({gnt, rom_addr, rsp_valid, rsp_data} !== {e_gnt, e_addr, e_rv, e_data}) begin
        n_fail++;
        $display("FAIL reset_prefill cyc=%0d gnt=%b/%b addr=%h/%h rv=%b/%b data=%h/%h",
                 cyc, gnt, e_gnt, rom_addr, e_addr, rsp_valid, e_rv, rsp_data, e_data);
      end
    end
    // two reads now in flight; reset mid-cycle must clear outputs at once
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({gnt, rom_addr, rsp_valid, rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_async gnt=%b rom_addr=%h rsp_valid=%b rsp_data=%h want all 0",
               gnt, rom_addr, rsp_valid, rsp_data);
    end
    req = '0;
    repeat (2) @(posedge vga_clk);
    #3;
    reset_n = 1'b1;
    m_reset();
    repeat (5) begin
      tick();
      n_chk++;
      if (rsp_valid !== '0 || {gnt, rom_addr, rsp_data} !== {e_gnt, e_addr, e_data}) begin
        n_fail++;
        $display("FAIL reset_flush cyc=%0d rsp_valid=%b want 0 gnt=%b rom_addr=%h rsp_data=%h",
                 cyc, rsp_valid, gnt, rom_addr, rsp_data);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    addr[2*AW +: AW] = 17'h00A5F;
    req = 4'b0100;
    tick();
    req = '0;
    n_chk++;
    if (gnt !== 4'b0100 || rom_addr !== 17'h00A5F) begin
      n_fail++;
      $display("FAIL single_gnt gnt=%b rom_addr=%h want 0100 00a5f", gnt, rom_addr);
    end
    for (int t = 1; t <= ROM_LAT + 1; t++) begin
      tick();
      n_chk++;
      if ({gnt, rom_addr, rsp_valid, rsp_data} !== {e_gnt, e_addr, e_rv, e_data}) begin
        n_fail++;
        $display("FAIL single_model cyc=%0d gnt=%b/%b addr=%h/%h rv=%b/%b data=%h/%h",
                 cyc, gnt, e_gnt, rom_addr, e_addr, rsp_valid, e_rv, rsp_data, e_data);
      end
      if (t == ROM_LAT) begin
        n_chk++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 4'hF) begin
          n_fail++;
          $display("FAIL single_rsp rsp_valid=%b rsp_data=%h want 0100 f", rsp_valid, rsp_data);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] want;
    do_reset();
    for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = AW'($urandom);
    req = 4'b1111;
    for (int t = 0; t < 8 + ROM_LAT + 1; t++) begin
      if (t == 8) req = '0;
      tick();
      n_chk++;
      if ({gnt, rom_addr, rsp_valid, rsp_data} !== {e_gnt, e_addr, e_rv, e_data}) begin
        n_fail++;
        $display("FAIL rr_model cyc=%0d gnt=%b/%b addr=%h/%h rv=%b/%b data=%h/%h",
                 cyc, gnt, e_gnt, rom_addr, e_addr, rsp_valid, e_rv, rsp_data, e_data);
      end
      if (t < 8) begin
`ifdef ROM_ARB_PRIORITY0_EN
        want = 4'b0001;
`else
        want = NREQ'(1) << (t % NREQ);
`endif
        n_chk++;
        if (gnt !== want) begin
          n_fail++;
          $display("FAIL rr_order t=%0d gnt=%b want %b", t, gnt, want);
        end
      end
    end
  endtask

  task automatic test_priority();
    int ord [8];
`ifdef ROM_ARB_PRIORITY0_EN
    ord = '{0, 0, 0, 0, 1, 2, 3, 1};
`else
    ord = '{0, 1, 2, 3, 1, 2, 3, 1};
`endif
    do_reset();
    for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = AW'($urandom);
    req = 4'b1111;
    for (int t = 0; t < 8 + ROM_LAT + 1; t++) begin
      if (t == 4) req = 4'b1110;
      if (t == 8) req = '0;
      tick();
      n_chk++;
      if ({gnt, rom_addr, rsp_valid, rsp_data} !== {e_gnt, e_addr, e_rv, e_data}) begin
        n_fail++;
        $display("FAIL prio_model cyc=%0d gnt=%b/%b addr=%h/%h rv=%b/%b data=%h/%h",
                 cyc, gnt, e_gnt, rom_addr, e_addr, rsp_valid, e_rv, rsp_data, e_data);
      end
      if (t < 8) begin
        n_chk++;
        if (gnt !== (NREQ'(1) << ord[t])) begin
          n_fail++;
          $display("FAIL prio_order t=%0d gnt=%b want idx %0d", t, gnt, ord[t]);
        end
      end
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = AW'($urandom);
    req = 4'b1001;
    for (int t = 0; t < ROM_LAT + 3; t++) begin
      tick();
      req = '0;
      n_chk++;
      if (gnt[3] !== 1'b0 || rsp_valid[3] !== 1'b0 ||
          {gnt, rom_addr, rsp_valid, rsp_data} !== {e_gnt, e_addr, e_rv, e_data}) begin
        n_fail++;
        $display("FAIL withdraw cyc=%0d gnt=%b/%b rv=%b/%b data=%h/%h",
                 cyc, gnt, e_gnt, rsp_valid, e_rv, rsp_data, e_data);
      end
    end
    // pointer now at 1: with requesters 0,2,3 asking, 2 wins in pure round robin
    req = 4'b1101;
    tick();
    req = '0;
    n_chk++;
`ifdef ROM_ARB_PRIORITY0_EN
    if (gnt !== 4'b0001) begin
`else
    if (gnt !== 4'b0100) begin
`endif
      n_fail++;
      $display("FAIL withdraw_ptr gnt=%b model=%b", gnt, e_gnt);
    end
    repeat (ROM_LAT + 1) tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] nib [NREQ];
    int            ord [4];
    int            t0;
`ifdef ROM_ARB_PRIORITY0_EN
    ord = '{0, 0, 0, 0};
`else
    ord = '{0, 1, 2, 3};
`endif
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW] = AW'($urandom_range(0, 'h1FFFF));
      nib[i] = addr[i*AW +: DW];
    end
    req = 4'b1111;
    for (int t = 1; t <= 4 + ROM_LAT + 1; t++) begin
      if (t == 5) req = '0;
      tick();
      n_chk++;
      if ({gnt, rom_addr, rsp_valid, rsp_data} !== {e_gnt, e_addr, e_rv, e_data}) begin
        n_fail++;
        $display("FAIL b2b_model cyc=%0d gnt=%b/%b addr=%h/%h rv=%b/%b data=%h/%h",
                 cyc, gnt, e_gnt, rom_addr, e_addr, rsp_valid, e_rv, rsp_data, e_data);
      end
      t0 = t - ROM_LAT - 1;
      if (t0 >= 0 && t0 < 4) begin
        n_chk++;
        if (rsp_valid !== (NREQ'(1) << ord[t0]) || rsp_data !== nib[ord[t0]]) begin
          n_fail++;
          $display("FAIL b2b_rsp k=%0d rsp_valid=%b rsp_data=%h want idx %0d data %h",
                   t0, rsp_valid, rsp_data, ord[t0], nib[ord[t0]]);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      tick();
      n_chk++;
      if (!$onehot0(gnt) || !$onehot0(rsp_valid) ||
          {gnt, rom_addr, rsp_valid, rsp_data} !== {e_gnt, e_addr, e_rv, e_data}) begin
        n_fail++;
        $display("FAIL random cyc=%0d gnt=%b/%b addr=%h/%h rv=%b/%b data=%h/%h",
                 cyc, gnt, e_gnt, rom_addr, e_addr, rsp_valid, e_rv, rsp_data, e_data);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            addr[i*AW +: AW] = AW'($urandom);
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    repeat (ROM_LAT + 1) tick();
  endtask

  initial begin
    cyc = 0;
    m_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_priority();
    test_withdraw();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
